// File: rtl/dsi_framer_pkg.sv
// DSI packet framer shared types, ECC and CRC16 helpers.
// Used by dsi_packet_framer and dsi_crc16_3b.
package dsi_framer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      ECC,
      PAYLOAD,
      CRC
   } state_t;

   localparam logic [15:0] c_crc_poly = 16'h8408;

   // Hamming parity masks over {wc_hi, wc_lo, di}, index = parity bit
   localparam logic [5:0][23:0] c_ecc_mask = {
      24'hEFFC00,
      24'hDF03F0,
      24'hB8E38E,
      24'h749A6D,
      24'hF2555B,
      24'hF12CB7
   };

   function automatic logic [7:0] dsi_ecc(input logic [23:0] d);
      logic [7:0] e;
      e = '0;
      for (int p = 0; p < 6; p++) begin
         e[p] = ^(d & c_ecc_mask[p]);
      end
      return e;
   endfunction

   function automatic logic [15:0] crc16_byte(
      input logic [15:0] crc,
      input logic [7:0]  b
   );
      logic [15:0] c;
      c = crc ^ {8'h00, b};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ c_crc_poly) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/dsi_crc16_3b.sv
// CRC16-CCITT (reflected) register updated by 1..3 bytes per cycle.
// Bytes arrive left-aligned in data_i, first byte in [23:16].
import dsi_framer_pkg::*;

module dsi_crc16_3b #(
   parameter logic [15:0] g_crc_init = 16'hFFFF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic [1:0]  size_i,
   input  logic [23:0] data_i,
   output logic [15:0] crc_o
);

   logic [15:0] crc_q;
   logic [15:0] crc_nxt;

   always_comb begin
      crc_nxt = crc_q;
      if (size_i != 2'd0) crc_nxt = crc16_byte(crc_nxt, data_i[23:16]);
      if (size_i >= 2'd2) crc_nxt = crc16_byte(crc_nxt, data_i[15:8]);
      if (size_i == 2'd3) crc_nxt = crc16_byte(crc_nxt, data_i[7:0]);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         crc_q <= g_crc_init;
      end else if (clr_i) begin
         crc_q <= g_crc_init;
      end else if (en_i) begin
         crc_q <= crc_nxt;
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/dsi_packet_framer.sv
// DSI short/long packet framer: header, ECC, payload, CRC16 beats of 1..3 bytes.
// Define DSI_FRAMER_CRC_EN to compute the payload CRC; otherwise the CRC beat is zero.
import dsi_framer_pkg::*;

module dsi_packet_framer #(
   parameter int          g_bytes    = 3,
   parameter logic [15:0] g_crc_init = 16'hFFFF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_long_i,
   input  logic [1:0]  cmd_vc_i,
   input  logic [5:0]  cmd_dt_i,
   input  logic [15:0] cmd_wc_i,
   input  logic [23:0] pix_i,
   input  logic        pix_valid_i,
   output logic        pix_ready_o,
   output logic [23:0] d_o,
   output logic [3:0]  d_size_o,
   output logic        d_valid_o,
   input  logic        d_req_i,
   output logic        busy_o
);

   if (g_bytes != 3) begin : g_bad_width
      $error("dsi_packet_framer supports g_bytes = 3 only");
   end

   state_t      state_q;
   logic [7:0]  di_q;
   logic [7:0]  ecc_q;
   logic [15:0] wc_q;
   logic [15:0] rem_q;
   logic        long_q;
   logic        rdy_q;
   logic [1:0]  n;
   logic [15:0] crc;
   logic        beat;
   logic        accept;

   assign n      = (rem_q >= 16'd3) ? 2'd3 : rem_q[1:0];
   assign accept = cmd_valid_i & rdy_q;

   always_comb begin
      beat = 1'b0;
      unique case (state_q)
         HDR, ECC, CRC: beat = d_req_i;
         PAYLOAD:       beat = d_req_i & pix_valid_i;
         default:       beat = 1'b0;
      endcase
   end

   assign d_valid_o   = beat;
   assign pix_ready_o = beat & (state_q == PAYLOAD);
   assign cmd_ready_o = rdy_q;
   assign busy_o      = (state_q != IDLE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         di_q    <= '0;
         ecc_q   <= '0;
         wc_q    <= '0;
         rem_q   <= '0;
         long_q  <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               rdy_q <= ~accept;
               if (accept) begin
                  di_q    <= {cmd_vc_i, cmd_dt_i};
                  wc_q    <= cmd_wc_i;
                  rem_q   <= cmd_wc_i;
                  long_q  <= cmd_long_i;
                  ecc_q   <= dsi_ecc({cmd_wc_i, cmd_vc_i, cmd_dt_i});
                  state_q <= HDR;
               end
            end
            HDR: begin
               if (beat) state_q <= ECC;
            end
            ECC: begin
               if (beat) begin
                  if (!long_q) begin
                     state_q <= IDLE;
                     rdy_q   <= 1'b1;
                  end else if (rem_q == 16'd0) begin
                     state_q <= CRC;
                  end else begin
                     state_q <= PAYLOAD;
                  end
               end
            end
            PAYLOAD: begin
               if (beat) begin
                  rem_q <= rem_q - {14'd0, n};
                  if (rem_q == {14'd0, n}) state_q <= CRC;
               end
            end
            CRC: begin
               if (beat) begin
                  state_q <= IDLE;
                  rdy_q   <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Beats are right-justified: first byte sits at d_o[8*size-1 -: 8]
   always_comb begin
      d_o      = '0;
      d_size_o = 4'd0;
      unique case (state_q)
         HDR: begin
            d_o      = {di_q, wc_q[7:0], wc_q[15:8]};
            d_size_o = 4'd3;
         end
         ECC: begin
            d_o      = {16'h0000, ecc_q};
            d_size_o = 4'd1;
         end
         PAYLOAD: begin
            d_size_o = {2'b00, n};
            unique case (n)
               2'd3:    d_o = pix_i;
               2'd2:    d_o = {8'h00, pix_i[23:8]};
               default: d_o = {16'h0000, pix_i[23:16]};
            endcase
         end
         CRC: begin
            d_o      = {8'h00, crc[7:0], crc[15:8]};
            d_size_o = 4'd2;
         end
         default: begin
            d_o      = '0;
            d_size_o = 4'd0;
         end
      endcase
   end

`ifdef DSI_FRAMER_CRC_EN
   dsi_crc16_3b #(
      .g_crc_init(g_crc_init)
   ) u_crc (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (accept | (beat & (state_q == CRC))),
      .en_i   (pix_ready_o),
      .size_i (n),
      .data_i (pix_i),
      .crc_o  (crc)
   );
`else
   // No CRC engine: seed is irrelevant and the CRC beat carries zeros
   assign crc = g_crc_init & 16'h0000;
`endif

endmodule

// File: tb/tb_dsi_packet_framer.sv
// Self-checking bench for dsi_packet_framer against a byte-level packet model.
// Honors DSI_FRAMER_CRC_EN to pick the expected CRC beat contents.
module tb_dsi_packet_framer;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic        cmd_long_i;
   logic [1:0]  cmd_vc_i;
   logic [5:0]  cmd_dt_i;
   logic [15:0] cmd_wc_i;
   logic [23:0] pix_i;
   logic        pix_valid_i;
   logic        pix_ready_o;
   logic [23:0] d_o;
   logic [3:0]  d_size_o;
   logic        d_valid_o;
   logic        d_req_i;
   logic        busy_o;

   always #5 clk_i = ~clk_i;

   dsi_packet_framer dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_long_i  (cmd_long_i),
      .cmd_vc_i    (cmd_vc_i),
      .cmd_dt_i    (cmd_dt_i),
      .cmd_wc_i    (cmd_wc_i),
      .pix_i       (pix_i),
      .pix_valid_i (pix_valid_i),
      .pix_ready_o (pix_ready_o),
      .d_o         (d_o),
      .d_size_o    (d_size_o),
      .d_valid_o   (d_valid_o),
      .d_req_i     (d_req_i),
      .busy_o      (busy_o)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [23:0] pix_src[$];
   logic [27:0] got_q[$];
   logic [27:0] exp_q[$];
   logic [27:0] ref_q[$];

   // Syndrome column of each header bit D0..D23
   localparam logic [5:0] c_ecc_col [24] = '{
      6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
      6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
      6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
   };

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ecc_model(input logic [23:0] d);
      logic [5:0] e;
      e = '0;
      for (int i = 0; i < 24; i++) if (d[i]) e ^= c_ecc_col[i];
      return {2'b00, e};
   endfunction

   // Bit-serial reflected CCITT, LSB of each byte first
   function automatic logic [15:0] crc_model(input logic [15:0] c,
                                             input logic [7:0] b);
      logic fb;
      for (int i = 0; i < 8; i++) begin
         fb = c[0] ^ b[i];
         c  = c >> 1;
         if (fb) c ^= 16'h8408;
      end
      return c;
   endfunction

   task automatic build_exp(input bit lng, input logic [1:0] vc,
                            input logic [5:0] dt, input logic [15:0] wc);
      logic [7:0]  di;
      logic [15:0] crc;
      logic [23:0] w;
      logic [23:0] p;
      logic [7:0]  b;
      int rem, k, n;
      di = {vc, dt};
      exp_q.push_back({4'd3, di, wc[7:0], wc[15:8]});
      exp_q.push_back({4'd1, 16'h0000, ecc_model({wc, di})});
      if (lng) begin
         crc = 16'hFFFF;
         rem = int'(wc);
         k   = 0;
         while (rem > 0) begin
            n = (rem < 3) ? rem : 3;
            p = pix_src[k];
            w = '0;
            for (int j = 0; j < n; j++) begin
               b   = p[23-8*j -: 8];
               crc = crc_model(crc, b);
               w   = {w[15:0], b};
            end
            exp_q.push_back({4'(n), w});
            k++;
            rem -= n;
         end
`ifdef DSI_FRAMER_CRC_EN
         exp_q.push_back({4'd2, 8'h00, crc[7:0], crc[15:8]});
`else
         exp_q.push_back({4'd2, 24'h000000});
`endif
      end
   endtask

   task automatic run_pkt(input bit lng, input logic [1:0] vc,
                          input logic [5:0] dt, input logic [15:0] wc,
                          input bit stall, input int abort_pl,
                          input string tag);
      int k = 0;
      int beats = 0;
      int nexp;
      bit acc = 0;
      bit pstall = 0;
      logic [27:0] pbeat = '0;
      got_q.delete();
      exp_q.delete();
      build_exp(lng, vc, dt, wc);
      nexp = exp_q.size();
      cmd_long_i  = lng;
      cmd_vc_i    = vc;
      cmd_dt_i    = dt;
      cmd_wc_i    = wc;
      cmd_valid_i = 1'b1;
      for (int c = 0; c < 4 * nexp + 40; c++) begin
         d_req_i     = stall ? ~c[0] : 1'b1;
         pix_valid_i = (k < pix_src.size()) &&
                       (!stall || $urandom_range(0, 2) != 0);
         pix_i       = (k < pix_src.size()) ? pix_src[k] : 24'h0;
         @(negedge clk_i);
         if (!d_req_i) chk({tag, "/no_req_beat"}, 32'(d_valid_o), 32'd0);
         if (pstall && busy_o)
            chk({tag, "/stall_hold"}, 32'({d_size_o, d_o}), 32'(pbeat));
         if (cmd_valid_i && cmd_ready_o) acc = 1;
         if (d_valid_o) begin
            got_q.push_back({d_size_o, d_o});
            beats++;
         end
         if (pix_ready_o) k++;
         pstall = busy_o && !d_valid_o;
         pbeat  = {d_size_o, d_o};
         @(posedge clk_i);
         #1;
         if (acc) cmd_valid_i = 1'b0;
         if (abort_pl >= 0 && beats == 2 + abort_pl) begin
            d_req_i     = 1'b1;
            pix_valid_i = 1'b1;
            rst_i       = 1'b1;
            #1;
            chk({tag, "/rst_outputs"},
                32'({d_o, d_size_o, d_valid_o, cmd_ready_o,
                     pix_ready_o, busy_o}), 32'd0);
            @(posedge clk_i);
            #1;
            rst_i       = 1'b0;
            pix_valid_i = 1'b0;
            return;
         end
         if (beats == nexp) break;
      end
      chk({tag, "/beat_count"}, 32'(beats), 32'(nexp));
      for (int i = 0; i < nexp && i < got_q.size(); i++)
         chk($sformatf("%s/beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      d_req_i     = 1'b1;
      pix_valid_i = 1'b0;
      @(negedge clk_i);
      chk({tag, "/busy_drop"}, 32'(busy_o), 32'd0);
      chk({tag, "/ready_next"}, 32'(cmd_ready_o), 32'd1);
      @(posedge clk_i);
      #1;
   endtask

   task automatic fill_pix(input int nb);
      pix_src.delete();
      for (int i = 0; i < nb; i++) pix_src.push_back(24'($urandom));
   endtask

   initial begin
      int ta, tb, nacc, beats;
      bit lng;
      logic [15:0] wc;
      rst_i       = 1'b1;
      cmd_valid_i = 1'b0;
      cmd_long_i  = 1'b0;
      cmd_vc_i    = '0;
      cmd_dt_i    = '0;
      cmd_wc_i    = '0;
      pix_i       = '0;
      pix_valid_i = 1'b0;
      d_req_i     = 1'b1;
      @(negedge clk_i);
      chk("reset_outputs",
          32'({d_o, d_size_o, d_valid_o, cmd_ready_o, pix_ready_o, busy_o}),
          32'd0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      pix_src.delete();
      run_pkt(0, 2'd0, 6'h05, 16'h0011, 0, -1, "short");
      chk("short/hdr_const", 32'(got_q[0]), 32'h3051100);

      run_pkt(1, 2'd1, 6'h39, 16'h0000, 0, -1, "zero_len");
      chk("zero_len/hdr_const", 32'(got_q[0]), 32'h3790000);
`ifdef DSI_FRAMER_CRC_EN
      chk("zero_len/crc_const", 32'(got_q[2]), 32'h200FFFF);
`else
      chk("zero_len/crc_const", 32'(got_q[2]), 32'h2000000);
`endif

      pix_src = '{24'hAABBCC, 24'hDDEEFF, 24'h112233};
      run_pkt(1, 2'd0, 6'h29, 16'd7, 0, -1, "odd");
      chk("odd/last_byte", 32'(got_q[4]), 32'h1000011);

      fill_pix(10);
      run_pkt(1, 2'd2, 6'h3E, 16'd30, 0, -1, "bp_ref");
      ref_q = got_q;
      run_pkt(1, 2'd2, 6'h3E, 16'd30, 1, -1, "bp_stall");
      chk("bp/len_equal", 32'(got_q.size()), 32'(ref_q.size()));
      for (int i = 0; i < ref_q.size() && i < got_q.size(); i++)
         chk($sformatf("bp/stream%0d", i), 32'(got_q[i]), 32'(ref_q[i]));

      fill_pix(10);
      run_pkt(1, 2'd2, 6'h1A, 16'd30, 0, 2, "abort");
      fill_pix(2);
      run_pkt(1, 2'd3, 6'h19, 16'd5, 0, -1, "post_rst");

      pix_src.delete();
      got_q.delete();
      exp_q.delete();
      build_exp(0, 2'd0, 6'h05, 16'h1234);
      build_exp(0, 2'd3, 6'h21, 16'hBEEF);
      cmd_long_i  = 1'b0;
      cmd_vc_i    = 2'd0;
      cmd_dt_i    = 6'h05;
      cmd_wc_i    = 16'h1234;
      cmd_valid_i = 1'b1;
      d_req_i     = 1'b1;
      ta = -1;
      tb = -100;
      nacc = 0;
      beats = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk_i);
         if (cmd_valid_i && cmd_ready_o) nacc++;
         if (d_valid_o) begin
            got_q.push_back({d_size_o, d_o});
            if (beats == 1) ta = c;
            if (beats == 2) tb = c;
            beats++;
         end
         @(posedge clk_i);
         #1;
         if (nacc == 1) begin
            cmd_vc_i = 2'd3;
            cmd_dt_i = 6'h21;
            cmd_wc_i = 16'hBEEF;
         end
         if (nacc >= 2) cmd_valid_i = 1'b0;
         if (beats == 4) break;
      end
      cmd_valid_i = 1'b0;
      chk("b2b/beats", 32'(beats), 32'd4);
      chk("b2b/gap", 32'(tb - ta), 32'd2);
      for (int i = 0; i < 4 && i < got_q.size(); i++)
         chk($sformatf("b2b/beat%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
      @(posedge clk_i);
      #1;

      for (int r = 0; r < 8; r++) begin
         lng = 1'($urandom);
         wc  = lng ? 16'($urandom_range(0, 40)) : 16'($urandom);
         fill_pix(lng ? (int'(wc) + 2) / 3 : 0);
         run_pkt(lng, 2'($urandom), 6'($urandom), wc, 1'($urandom), -1,
                 $sformatf("rnd%0d", r));
      end

      fill_pix(21845);
      run_pkt(1, 2'd1, 6'h3E, 16'hFFFF, 0, -1, "max_wc");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
